// File: rtl/mdu_div_ctrl_pkg.sv
// Shared encodings and helpers for the multi-cycle divide controller.
package mdu_div_ctrl_pkg;

    localparam int unsigned DIV_W = 32;
    localparam int unsigned CNT_W = 6;

    // Stall request values driven towards the pipeline stall controller
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Two's-complement magnitude when neg is set, raw value otherwise
    function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v, input logic neg);
        return neg ? (~v + DIV_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mdu_div_ctrl.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up on completion, result held until EX drops start_i.
module mdu_div_ctrl
    import mdu_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_req_o
);

    localparam int unsigned LAST_STEP = WIDTH - 1;

    div_state_e         state_q;
    div_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dividend_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   rem_q;
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic               accept;
    logic               last_step;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quot;
    logic [WIDTH-1:0]   fin_quot;
    logic [WIDTH-1:0]   fin_rem;

    assign accept    = (state_q == DIV_FREE) && start_i && !annul_i;
    assign last_step = (cnt_q == CNT_W'(LAST_STEP));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a flush always returns to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                state_d = annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (last_step) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                if (annul_i || !start_i) begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // Stall request: held while a divide is being accepted or computed
    always_comb begin
        stall_req_o = NO_STOP;
        case (state_q)
            DIV_FREE:            if (start_i && !annul_i) stall_req_o = STOP;
            DIV_BY_ZERO, DIV_ON: stall_req_o = STOP;
            default:             stall_req_o = NO_STOP;
        endcase
    end

    // One restoring step plus the sign fix-up applied to the final step
    always_comb begin
        trial     = {rem_q, dividend_q[WIDTH-1]};
        diff      = trial - {1'b0, divisor_q};
        step_rem  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        step_quot = {dividend_q[WIDTH-2:0], ~diff[WIDTH]};
        fin_quot  = neg_quot_q ? (~step_quot + WIDTH'(1)) : step_quot;
        fin_rem   = neg_rem_q  ? (~step_rem  + WIDTH'(1)) : step_rem;
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            cnt_q      <= '0;
            dividend_q <= magnitude(opdata1_i, signed_i & opdata1_i[WIDTH-1]);
            divisor_q  <= magnitude(opdata2_i, signed_i & opdata2_i[WIDTH-1]);
            rem_q      <= '0;
            neg_quot_q <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_i & opdata1_i[WIDTH-1];
        end else if (state_q == DIV_ON) begin
            cnt_q      <= cnt_q + CNT_W'(1);
            dividend_q <= step_quot;
            rem_q      <= step_rem;
        end
    end

    // Result and ready registers: only ever non-zero while in DIV_END
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= (state_d == DIV_END);
            if (state_d != DIV_END) begin
                result_q <= '0;
            end else if (state_q == DIV_ON) begin
                result_q <= {fin_rem, fin_quot};
            end else if (state_q == DIV_BY_ZERO) begin
                result_q <= '0;
            end
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
